// File: rtl/stack_pkg.sv
// Shared command encoding and default geometry for the parametrised LIFO stack.
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2,
        CMD_GET  = 2'd3
    } stack_cmd_e;

    localparam int STACK_WIDTH = 4;
    localparam int STACK_DEPTH = 5;

endpackage

// File: rtl/stack_ptr_mod.sv
// Ring-pointer adder/subtractor: o_ptr = (i_ptr +/- i_off) mod DEPTH, chosen by SUB.
// Valid for i_ptr < DEPTH and i_off <= DEPTH; DEPTH need not be a power of two.
module stack_ptr_mod #(
    parameter int DEPTH = 5,
    parameter bit SUB   = 1'b0,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OFF_W = $clog2(DEPTH + 1)
) (
    input  logic [PTR_W-1:0] i_ptr,
    input  logic [OFF_W-1:0] i_off,
    output logic [PTR_W-1:0] o_ptr
);
    localparam int EXT_W = OFF_W + 1;
    localparam logic [EXT_W-1:0] DEPTH_X = EXT_W'(DEPTH);

    logic [EXT_W-1:0] w_ptr_x;
    logic [EXT_W-1:0] w_off_x;
    logic [EXT_W-1:0] w_sum;
    logic [EXT_W-1:0] w_add;
    logic [EXT_W-1:0] w_sub;
    logic             w_unused;

    assign w_ptr_x = EXT_W'(i_ptr);
    assign w_off_x = EXT_W'(i_off);
    assign w_sum   = w_ptr_x + w_off_x;

    // Both operands stay below 2*DEPTH, so a single conditional correction wraps the result.
    assign w_add = (w_sum >= DEPTH_X) ? (w_sum - DEPTH_X) : w_sum;
    assign w_sub = (w_ptr_x >= w_off_x) ? (w_ptr_x - w_off_x) : (w_ptr_x + DEPTH_X - w_off_x);

    assign o_ptr    = SUB ? w_sub[PTR_W-1:0] : w_add[PTR_W-1:0];
    assign w_unused = ^{w_add[EXT_W-1:PTR_W], w_sub[EXT_W-1:PTR_W]};

endmodule

// File: rtl/stack_param.sv
// Parametrised synchronous LIFO stack: ring storage, registered result, occupancy flags, error pulse.
// Define STACK_STRICT_OVERFLOW_EN to reject PUSH on a full stack instead of overwriting the oldest entry.
module stack_param
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       COMMAND,
    input  logic [IDX_W-1:0] INDEX,
    input  logic [WIDTH-1:0] I_DATA,
    output logic [WIDTH-1:0] O_DATA,
    output logic             O_VALID,
    output logic             ERR,
    output logic             FULL,
    output logic             EMPTY,
    output logic [CNT_W-1:0] COUNT
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_err;

    stack_cmd_e       w_cmd;
    logic [IDX_W-1:0] w_top_inc;
    logic [IDX_W-1:0] w_top_dec;
    logic [IDX_W-1:0] w_get_addr;
    logic [CNT_W-1:0] w_idx_ext;
    logic [CNT_W-1:0] w_get_off;
    logic             w_full;
    logic             w_empty;
    logic             w_idx_ok;

    assign w_cmd     = stack_cmd_e'(COMMAND);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_idx_ext = CNT_W'(INDEX);
    assign w_idx_ok  = (w_idx_ext < r_count);
    // Entry k below the top sits k+1 slots behind the free-slot pointer.
    assign w_get_off = w_idx_ext + CNT_W'(1);

    stack_ptr_mod #(.DEPTH(DEPTH), .SUB(1'b0)) u_top_inc (
        .i_ptr (r_top),
        .i_off (CNT_W'(1)),
        .o_ptr (w_top_inc)
    );

    stack_ptr_mod #(.DEPTH(DEPTH), .SUB(1'b1)) u_top_dec (
        .i_ptr (r_top),
        .i_off (CNT_W'(1)),
        .o_ptr (w_top_dec)
    );

    stack_ptr_mod #(.DEPTH(DEPTH), .SUB(1'b1)) u_get_addr (
        .i_ptr (r_top),
        .i_off (w_get_off),
        .o_ptr (w_get_addr)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_top   <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (w_cmd)
                CMD_NOP: begin
                end
                CMD_PUSH: begin
                    if (!w_full) begin
                        r_mem[r_top] <= I_DATA;
                        r_top        <= w_top_inc;
                        r_count      <= r_count + CNT_W'(1);
                    end else begin
`ifdef STACK_STRICT_OVERFLOW_EN
                        r_err <= 1'b1;
`else
                        // Overwrites the oldest entry; COUNT stays saturated at DEPTH.
                        r_mem[r_top] <= I_DATA;
                        r_top        <= w_top_inc;
                        r_err        <= 1'b1;
`endif
                    end
                end
                CMD_POP: begin
                    if (w_empty) begin
                        r_err <= 1'b1;
                    end else begin
                        r_top   <= w_top_dec;
                        r_count <= r_count - CNT_W'(1);
                        r_data  <= r_mem[w_top_dec];
                        r_valid <= 1'b1;
                    end
                end
                CMD_GET: begin
                    if (w_idx_ok) begin
                        r_data  <= r_mem[w_get_addr];
                        r_valid <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign O_DATA  = r_data;
    assign O_VALID = r_valid;
    assign ERR     = r_err;
    assign COUNT   = r_count;
    assign FULL    = w_full;
    assign EMPTY   = w_empty;

endmodule

// File: tb/tb_stack_param.sv
// Bench for stack_param: directed sequences on a 5x4 stack plus random command streams
// at DEPTH 2, 5 and 8 checked against a queue model through a per-instance scoreboard.
module tb_stack_param;
    import stack_pkg::*;

    typedef struct {
        string tag;
        logic  vld;
        logic  err;
        logic  full;
        logic  empty;
        int    dout;
        int    cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input exp_t e, input logic v, input logic er, input logic [31:0] dout,
                       input logic [31:0] cnt, input logic f, input logic em);
        check({e.tag, "_vld"},   v,    e.vld);
        check({e.tag, "_err"},   er,   e.err);
        check({e.tag, "_dout"},  dout, e.dout);
        check({e.tag, "_cnt"},   cnt,  e.cnt);
        check({e.tag, "_full"},  f,    e.full);
        check({e.tag, "_empty"}, em,   e.empty);
    endtask

    // ---------------- directed instance, 5 x 4 ----------------
    localparam int DW  = 4;
    localparam int DD  = 5;
    localparam int DIW = $clog2(DD);
    localparam int DCW = $clog2(DD + 1);

    logic           d_rst = 1'b1;
    logic [1:0]     d_cmd = 2'd0;
    logic [DIW-1:0] d_idx = '0;
    logic [DW-1:0]  d_din = '0;
    logic [DW-1:0]  d_dout;
    logic           d_vld;
    logic           d_err;
    logic           d_full;
    logic           d_empty;
    logic [DCW-1:0] d_cnt;
    exp_t           d_sb[$];

`ifdef STACK_STRICT_OVERFLOW_EN
    int ovf_pop[5] = '{5, 4, 3, 2, 1};
`else
    int ovf_pop[5] = '{6, 5, 4, 3, 2};
`endif

    stack_param #(.WIDTH(DW), .DEPTH(DD)) u_dut (
        .CLK     (clk),
        .RESET   (d_rst),
        .COMMAND (d_cmd),
        .INDEX   (d_idx),
        .I_DATA  (d_din),
        .O_DATA  (d_dout),
        .O_VALID (d_vld),
        .ERR     (d_err),
        .FULL    (d_full),
        .EMPTY   (d_empty),
        .COUNT   (d_cnt)
    );

    task automatic d_op(input string tag, input logic rst, input stack_cmd_e c, input int idx,
                        input int din, input logic e_vld, input logic e_err, input int e_dout,
                        input int e_cnt);
        exp_t e;
        exp_t got;
        d_rst = rst;
        d_cmd = c;
        d_idx = DIW'(idx);
        d_din = DW'(din);
        e.tag   = tag;
        e.vld   = e_vld;
        e.err   = e_err;
        e.dout  = e_dout;
        e.cnt   = e_cnt;
        e.full  = (e_cnt == DD);
        e.empty = (e_cnt == 0);
        d_sb.push_back(e);
        @(posedge clk);
        #1;
        got = d_sb.pop_front();
        cmp(got, d_vld, d_err, 32'(d_dout), 32'(d_cnt), d_full, d_empty);
    endtask

    // ---------------- random instances vs queue model ----------------
    generate
        for (genvar g = 0; g < 3; g++) begin : g_rnd
            localparam int D  = (g == 0) ? 2 : ((g == 1) ? 5 : 8);
            localparam int IW = $clog2(D);
            localparam int CW = $clog2(D + 1);

            logic          rst = 1'b1;
            logic [1:0]    cmd = 2'd0;
            logic [IW-1:0] idx = '0;
            logic [3:0]    din = '0;
            logic [3:0]    dout;
            logic          vld;
            logic          err;
            logic          full;
            logic          empty;
            logic [CW-1:0] cnt;
            logic          done = 1'b0;
            int            model[$];
            int            last = 0;
            exp_t          sb[$];

            stack_param #(.WIDTH(4), .DEPTH(D)) u_dut (
                .CLK     (clk),
                .RESET   (rst),
                .COMMAND (cmd),
                .INDEX   (idx),
                .I_DATA  (din),
                .O_DATA  (dout),
                .O_VALID (vld),
                .ERR     (err),
                .FULL    (full),
                .EMPTY   (empty),
                .COUNT   (cnt)
            );

            task automatic step(input logic r, input logic [1:0] c, input int ix, input int d);
                exp_t e;
                exp_t got;
                e.tag = $sformatf("rnd_d%0d", D);
                e.vld = 1'b0;
                e.err = 1'b0;
                if (r) begin
                    model.delete();
                    last = 0;
                end else begin
                    case (c)
                        2'd1: begin
                            if (model.size() < D) begin
                                model.push_back(d);
                            end else begin
`ifdef STACK_STRICT_OVERFLOW_EN
                                e.err = 1'b1;
`else
                                void'(model.pop_front());
                                model.push_back(d);
                                e.err = 1'b1;
`endif
                            end
                        end
                        2'd2: begin
                            if (model.size() == 0) begin
                                e.err = 1'b1;
                            end else begin
                                last  = model.pop_back();
                                e.vld = 1'b1;
                            end
                        end
                        2'd3: begin
                            if (ix < model.size()) begin
                                last  = model[model.size() - 1 - ix];
                                e.vld = 1'b1;
                            end else begin
                                e.err = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                e.dout  = last;
                e.cnt   = model.size();
                e.full  = (model.size() == D);
                e.empty = (model.size() == 0);
                rst = r;
                cmd = c;
                idx = IW'(ix);
                din = 4'(d);
                sb.push_back(e);
                @(posedge clk);
                #1;
                got = sb.pop_front();
                cmp(got, vld, err, 32'(dout), 32'(cnt), full, empty);
            endtask

            initial begin
                step(1'b1, 2'd0, 0, 0);
                for (int i = 0; i < 10000; i++) begin
                    step(($urandom_range(0, 299) == 0), 2'($urandom_range(0, 3)),
                         int'($urandom_range(0, (1 << IW) - 1)), int'($urandom_range(0, 15)));
                end
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        logic all_done;

        d_op("reset",     1'b1, CMD_NOP,  0, 0,    1'b0, 1'b0, 0,   0);
        d_op("push3",     1'b0, CMD_PUSH, 0, 'h3,  1'b0, 1'b0, 0,   1);
        d_op("push7",     1'b0, CMD_PUSH, 0, 'h7,  1'b0, 1'b0, 0,   2);
        d_op("push9",     1'b0, CMD_PUSH, 0, 'h9,  1'b0, 1'b0, 0,   3);
        d_op("pop9",      1'b0, CMD_POP,  0, 0,    1'b1, 1'b0, 'h9, 2);
        d_op("pop7",      1'b0, CMD_POP,  0, 0,    1'b1, 1'b0, 'h7, 1);
        d_op("pop3",      1'b0, CMD_POP,  0, 0,    1'b1, 1'b0, 'h3, 0);
        d_op("pop_empty", 1'b0, CMD_POP,  0, 0,    1'b0, 1'b1, 'h3, 0);
        d_op("get_empty", 1'b0, CMD_GET,  0, 0,    1'b0, 1'b1, 'h3, 0);
        for (int i = 0; i < 5; i++) begin
            d_op("push_fill", 1'b0, CMD_PUSH, 0, i + 1, 1'b0, 1'b0, 'h3, i + 1);
        end
        d_op("get0",      1'b0, CMD_GET,  0, 0,    1'b1, 1'b0, 5,   5);
        d_op("get4",      1'b0, CMD_GET,  4, 0,    1'b1, 1'b0, 1,   5);
        d_op("get5",      1'b0, CMD_GET,  5, 0,    1'b0, 1'b1, 1,   5);
        d_op("nop",       1'b0, CMD_NOP,  0, 0,    1'b0, 1'b0, 1,   5);
        d_op("push_full", 1'b0, CMD_PUSH, 0, 6,    1'b0, 1'b1, 1,   5);
        for (int i = 0; i < 5; i++) begin
            d_op("pop_ovf", 1'b0, CMD_POP, 0, 0, 1'b1, 1'b0, ovf_pop[i], 4 - i);
        end
        d_op("pushA",     1'b0, CMD_PUSH, 0, 'hA,  1'b0, 1'b0, ovf_pop[4], 1);
        d_op("pushB",     1'b0, CMD_PUSH, 0, 'hB,  1'b0, 1'b0, ovf_pop[4], 2);
        d_op("rst_push",  1'b1, CMD_PUSH, 0, 'hC,  1'b0, 1'b0, 0,   0);
        d_op("pop_post",  1'b0, CMD_POP,  0, 0,    1'b0, 1'b1, 0,   0);
        d_op("pushE",     1'b0, CMD_PUSH, 0, 'hE,  1'b0, 1'b0, 0,   1);
        d_op("popE",      1'b0, CMD_POP,  0, 0,    1'b1, 1'b0, 'hE, 0);
        d_op("idle",      1'b0, CMD_NOP,  0, 0,    1'b0, 1'b0, 'hE, 0);

        all_done = 1'b0;
        for (int i = 0; i < 20000 && !all_done; i++) begin
            @(posedge clk);
            all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done;
        end
        check("rnd_complete", 32'(all_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
